conv_window_gen: RTL and testbench

- Parametrised K x K sliding-window generator for the NPU convolution datapath.
- Each beat accepts one column of K vertically adjacent pixels from the line buffers and shifts it into a K x K register array.
- Tracks column position within an image row and honours a horizontal stride.
- Presents a full window with a valid/ready handshake to the downstream MAC array.

---
 rtl/npu_pkg.sv | 14 +
 rtl/conv_window_gen_if.sv | 30 +++
 rtl/window_col_shift.sv | 39 +++
 rtl/conv_window_gen.sv | 134 +++++++++++++
 tb/tb_conv_window_gen.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/npu_pkg.sv
// Shared NPU convolution types: pixel type and the (r,c) window packing
// helper, so every consumer of a window agrees on element placement.
package npu_pkg;

  localparam int NPU_BIT_DEPTH = 8;

  typedef logic [NPU_BIT_DEPTH-1:0] pixel_t;

  // Flat element index of window element (r,c); c=0 is the oldest column.
  function automatic int win_idx(input int r, input int c, input int k);
    return (r * k) + c;
  endfunction

endpackage

// File: rtl/conv_window_gen_if.sv
// Pixel-column input stream and window output stream of the window generator.
interface conv_window_gen_if #(
  parameter int BIT_DEPTH = 8,
  parameter int K         = 3,
  parameter int IMG_WIDTH = 28
);

  localparam int CW = $clog2(IMG_WIDTH);

  logic                       in_valid;
  logic                       in_ready;
  logic [K*BIT_DEPTH-1:0]     in_col;
  logic                       out_valid;
  logic                       out_ready;
  logic [K*K*BIT_DEPTH-1:0]   out_window;
  logic [CW-1:0]              out_col;

  // Upstream/downstream driver view.
  modport master (
    output in_valid, in_col, out_ready,
    input  in_ready, out_valid, out_window, out_col
  );

  // Window generator view.
  modport slave (
    input  in_valid, in_col, out_ready,
    output in_ready, out_valid, out_window, out_col
  );

endinterface

// File: rtl/window_col_shift.sv
// K-deep pixel shift chain for one window row; element 0 is the oldest pixel.
module window_col_shift
  import npu_pkg::*;
#(
  parameter int BIT_DEPTH = NPU_BIT_DEPTH,
  parameter int K         = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [BIT_DEPTH-1:0]   din,
  output logic [K*BIT_DEPTH-1:0] row
);

  logic [K*BIT_DEPTH-1:0] row_q;
  logic [K*BIT_DEPTH-1:0] row_d;

  // Shift toward element 0 on enable; the new pixel enters at element K-1.
  always_comb begin
    row_d = row_q;
    if (en) begin
      row_d = {din, row_q[K*BIT_DEPTH-1:BIT_DEPTH]};
    end else begin
      row_d = row_q;
    end
  end

  // Row storage register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q <= '0;
    end else begin
      row_q <= row_d;
    end
  end

  assign row = row_q;

endmodule

// File: rtl/conv_window_gen.sv
// K x K sliding-window generator: shifts pixel columns into K row chains,
// tracks column position and stride, and presents windows with valid/ready.
module conv_window_gen
  import npu_pkg::*;
#(
  parameter int BIT_DEPTH = NPU_BIT_DEPTH,
  parameter int K         = 3,
  parameter int IMG_WIDTH = 28,
  parameter int STRIDE    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  conv_window_gen_if.slave  bus
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int SW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  localparam logic [CW-1:0] LAST_COL    = CW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0] FIRST_EMIT  = CW'(K - 1);
  localparam logic [SW-1:0] LAST_STRIDE = SW'(STRIDE - 1);

  logic [CW-1:0] col_cnt_q, col_cnt_d;
  logic [SW-1:0] stride_cnt_q, stride_cnt_d;
  logic          out_valid_q, out_valid_d;
  logic [CW-1:0] out_col_q, out_col_d;

  logic                   in_ready_s;
  logic                   accept_s;
  logic                   shift_en_s;
  logic                   emit_s;
  logic [SW-1:0]          stride_eff_s;
  logic [K*BIT_DEPTH-1:0] rows_s [K];
  logic [K*K*BIT_DEPTH-1:0] win_s;

  // A held, unconsumed window blocks the input so the array never shifts under it.
  assign in_ready_s = !out_valid_q || bus.out_ready;
  assign accept_s   = bus.in_valid && in_ready_s;
  // A beat arriving together with clear is dropped and leaves the array intact.
  assign shift_en_s = accept_s && !clear;

  for (genvar g = 0; g < K; g++) begin : g_row
    window_col_shift #(
      .BIT_DEPTH (BIT_DEPTH),
      .K         (K)
    ) u_row (
      .clk (clk),
      .rst (rst),
      .en  (shift_en_s),
      .din (bus.in_col[g*BIT_DEPTH +: BIT_DEPTH]),
      .row (rows_s[g])
    );
  end

  // Flatten the row chains into the shared (r,c) window packing.
  always_comb begin
    win_s = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        win_s[win_idx(r, c, K)*BIT_DEPTH +: BIT_DEPTH] = rows_s[r][c*BIT_DEPTH +: BIT_DEPTH];
      end
    end
  end

  // Column/stride tracking, emission decision and output-valid update.
  always_comb begin
    col_cnt_d    = col_cnt_q;
    stride_cnt_d = stride_cnt_q;
    out_valid_d  = out_valid_q;
    out_col_d    = out_col_q;
    emit_s       = 1'b0;
    // The stride phase restarts at the first full window of each row.
    if (col_cnt_q == FIRST_EMIT) begin
      stride_eff_s = '0;
    end else begin
      stride_eff_s = stride_cnt_q;
    end

    if (clear) begin
      col_cnt_d    = '0;
      stride_cnt_d = '0;
      out_valid_d  = 1'b0;
    end else if (accept_s) begin
      emit_s = (col_cnt_q >= FIRST_EMIT) && (stride_eff_s == '0);
      if (col_cnt_q == LAST_COL) begin
        col_cnt_d    = '0;
        stride_cnt_d = '0;
      end else begin
        col_cnt_d = col_cnt_q + CW'(1);
        if (col_cnt_q < FIRST_EMIT) begin
          stride_cnt_d = '0;
        end else if (stride_eff_s == LAST_STRIDE) begin
          stride_cnt_d = '0;
        end else begin
          stride_cnt_d = stride_eff_s + SW'(1);
        end
      end
      if (emit_s) begin
        out_valid_d = 1'b1;
        out_col_d   = col_cnt_q - FIRST_EMIT;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = out_valid_q;
      end
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Counter and output-stage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_cnt_q    <= '0;
      stride_cnt_q <= '0;
      out_valid_q  <= 1'b0;
      out_col_q    <= '0;
    end else begin
      col_cnt_q    <= col_cnt_d;
      stride_cnt_q <= stride_cnt_d;
      out_valid_q  <= out_valid_d;
      out_col_q    <= out_col_d;
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_col    = out_col_q;
  assign bus.out_window = win_s;

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: two instances (K=3 W=6 S=1 and
// K=3 W=7 S=2) share one stimulus stream; each phase starts from a clear.
module tb_conv_window_gen;
  import npu_pkg::*;

  logic        clk;
  logic        rst;
  logic        clear;
  logic        in_valid;
  logic [23:0] in_col;
  logic        out_ready;

  int checks;
  int errors;
  int nwin;

  conv_window_gen_if #(.BIT_DEPTH(8), .K(3), .IMG_WIDTH(6)) ifa ();
  conv_window_gen_if #(.BIT_DEPTH(8), .K(3), .IMG_WIDTH(7)) ifb ();

  assign ifa.in_valid  = in_valid;
  assign ifa.in_col    = in_col;
  assign ifa.out_ready = out_ready;
  assign ifb.in_valid  = in_valid;
  assign ifb.in_col    = in_col;
  assign ifb.out_ready = out_ready;

  conv_window_gen #(.BIT_DEPTH(8), .K(3), .IMG_WIDTH(6), .STRIDE(1)) dut_a (
    .clk (clk), .rst (rst), .clear (clear), .bus (ifa)
  );

  conv_window_gen #(.BIT_DEPTH(8), .K(3), .IMG_WIDTH(7), .STRIDE(2)) dut_b (
    .clk (clk), .rst (rst), .clear (clear), .bus (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pixel at lane r of image column c: 100*row_tag + 10*c + r.
  function automatic logic [23:0] mk_col(input int c, input int tag);
    logic [23:0] v;
    pixel_t p;
    v = '0;
    for (int r = 0; r < 3; r++) begin
      p = pixel_t'(100*tag + 10*c + r);
      v[r*8 +: 8] = p;
    end
    return v;
  endfunction

  // Expected window whose leftmost column is image column first.
  function automatic logic [71:0] exp_win(input int first, input int tag);
    logic [71:0] w;
    w = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        w[(r*3 + c)*8 +: 8] = 8'(100*tag + 10*(first + c) + r);
      end
    end
    return w;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int c, input int tag);
    in_valid = 1'b1;
    in_col   = mk_col(c, tag);
    tick();
  endtask

  task automatic do_clear;
    in_valid = 1'b0;
    clear    = 1'b1;
    tick();
    clear    = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_col    = '0;
    out_ready = 1'b1;
    tick();
    tick();
    check("rst_valid",  72'(ifa.out_valid), 72'(0));
    check("rst_col",    72'(ifa.out_col), 72'(0));
    check("rst_window", ifa.out_window, 72'(0));
    check("rst_ready",  72'(ifa.in_ready), 72'(1));
    rst = 1'b0;
    tick();

    // Fill one row, stride 1: four windows at columns 0..3.
    nwin = 0;
    for (int c = 0; c < 6; c++) begin
      beat(c, 0);
      check("fill_valid", 72'(ifa.out_valid), 72'(c >= 2));
      if (ifa.out_valid) begin
        nwin++;
        check("fill_col", 72'(ifa.out_col), 72'(c - 2));
        check("fill_win", ifa.out_window, exp_win(c - 2, 0));
      end
      if (c == 2) begin
        check("fill_e00", 72'(ifa.out_window[7:0]), 72'(0));
        check("fill_e22", 72'(ifa.out_window[71:64]), 72'(22));
      end
    end
    in_valid = 1'b0;
    check("fill_count", 72'(nwin), 72'(4));

    // Stride 2 on the W=7 instance: windows at columns 0, 2, 4.
    do_clear();
    nwin = 0;
    for (int c = 0; c < 7; c++) begin
      beat(c, 0);
      check("stride_valid", 72'(ifb.out_valid), 72'((c >= 2) && (((c - 2) % 2) == 0)));
      if (ifb.out_valid) begin
        nwin++;
        check("stride_col", 72'(ifb.out_col), 72'(c - 2));
        check("stride_win", ifb.out_window, exp_win(c - 2, 0));
      end
    end
    in_valid = 1'b0;
    check("stride_count", 72'(nwin), 72'(3));

    // Backpressure: hold the first window for five cycles, then release.
    do_clear();
    for (int c = 0; c < 3; c++) beat(c, 0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_col    = mk_col(3, 0);
    #1;
    check("bp_ready0", 72'(ifa.in_ready), 72'(0));
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_ready", 72'(ifa.in_ready), 72'(0));
      check("bp_valid", 72'(ifa.out_valid), 72'(1));
      check("bp_col",   72'(ifa.out_col), 72'(0));
      check("bp_win",   ifa.out_window, exp_win(0, 0));
    end
    out_ready = 1'b1;
    tick();
    check("bp_rel_valid", 72'(ifa.out_valid), 72'(1));
    check("bp_rel_col",   72'(ifa.out_col), 72'(1));
    check("bp_rel_win",   ifa.out_window, exp_win(1, 0));
    in_valid = 1'b0;
    tick();
    check("bp_drain", 72'(ifa.out_valid), 72'(0));

    // Two rows back-to-back: eight windows, second row restarts at column 0.
    do_clear();
    nwin = 0;
    for (int row = 0; row < 2; row++) begin
      for (int c = 0; c < 6; c++) begin
        beat(c, row);
        check("wrap_valid", 72'(ifa.out_valid), 72'(c >= 2));
        if (ifa.out_valid) begin
          nwin++;
          check("wrap_col", 72'(ifa.out_col), 72'(c - 2));
          check("wrap_win", ifa.out_window, exp_win(c - 2, row));
        end
      end
    end
    in_valid = 1'b0;
    check("wrap_count", 72'(nwin), 72'(8));

    // Clear mid-row with a beat present: beat dropped, array untouched.
    do_clear();
    for (int c = 0; c < 4; c++) beat(c, 0);
    check("clr_pre_valid", 72'(ifa.out_valid), 72'(1));
    in_valid = 1'b1;
    in_col   = mk_col(4, 0);
    clear    = 1'b1;
    tick();
    clear    = 1'b0;
    check("clr_valid", 72'(ifa.out_valid), 72'(0));
    check("clr_win",   ifa.out_window, exp_win(1, 0));
    for (int c = 5; c < 8; c++) begin
      beat(c, 0);
      check("clr_re_valid", 72'(ifa.out_valid), 72'(c == 7));
    end
    in_valid = 1'b0;
    check("clr_re_col", 72'(ifa.out_col), 72'(0));
    check("clr_re_win", ifa.out_window, exp_win(5, 0));

    // Asynchronous reset between edges while a window is held.
    do_clear();
    for (int c = 0; c < 3; c++) beat(c, 0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("ar_pre_valid", 72'(ifa.out_valid), 72'(1));
    #2;
    rst = 1'b1;
    #1;
    check("ar_valid",  72'(ifa.out_valid), 72'(0));
    check("ar_window", ifa.out_window, 72'(0));
    check("ar_col",    72'(ifa.out_col), 72'(0));
    check("ar_ready",  72'(ifa.in_ready), 72'(1));
    #2;
    rst = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
